mod_instr_fetch: RTL and testbench

Single-issue instruction fetch stage that sits directly upstream of the control unit. It owns the program counter and fetches one 32-bit word at a time over a request/acknowledge instruction-memory port. It holds the word in an instruction register and presents the decoded fields (opcode, funct, register indices, immediate) to the control unit and datapath. It then computes the next PC from the branch/jump/zero decisions returned for the presented instruction.

---
 rtl/mod_instr_fetch.sv | 77 +++++++
 tb/tb_mod_instr_fetch.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mod_instr_fetch.sv
// mod_instr_fetch: single-issue fetch stage with PC, instruction register and next-PC selection.
module mod_instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [31:0] imm_sext,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr_count
);
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;
  localparam logic [31:0] PC0 = RESET_PC & ~32'd3;
  state_t state;
  logic [31:0] next_pc;
  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];
  assign rs        = instr[25:21];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign imm_sext  = {{16{instr[15]}}, instr[15:0]};
  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  // jump outranks a taken branch
  assign next_pc = jump ? {pc_plus4[31:28], instr[25:0], 2'b00} :
                   (branch && zero) ? pc_plus4 + {imm_sext[29:0], 2'b00} : pc_plus4;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= PC0;
      instr       <= '0;
      instr_count <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: if (imem_ack) begin
          instr       <= imem_rdata;
          state       <= ISSUE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b1;
        end
        ISSUE: if (!stall) begin
          pc          <= next_pc;
          instr_count <= instr_count + 32'd1;
          state       <= FETCH;
          imem_req    <= 1'b1;
          instr_valid <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mod_instr_fetch.sv
// tb_mod_instr_fetch: scoreboard bench for fetch addresses and issued instructions.
module tb_mod_instr_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst2_n = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'hDEAD_BEEF;
  logic        stall = 1'b0, branch = 1'b0, jump = 1'b0, zero = 1'b0;
  logic        instr_valid;
  logic [31:0] instr, imm_sext, pc, pc_plus4, instr_count;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic        x_ack = 1'b1, x_zero = 1'b0;
  logic [31:0] x_rdata = 32'h012A_4020;
  logic        x_req[2], x_valid[2];
  logic [31:0] x_addr[2], x_instr[2], x_imm[2], x_pc[2], x_pc4[2], x_cnt[2];
  logic [5:0]  x_op[2], x_fn[2];
  logic [4:0]  x_rs[2], x_rt[2], x_rd[2];
  int total = 0, bad = 0;
  logic [31:0]  aq[$], wq[$], oq[$];
  logic [154:0] iq[$];
  localparam logic [31:0] W = 32'h012A_4020, WB = 32'h1109_FFFC, WJ1 = 32'h0BFF_FFFF, WJ2 = 32'h0800_0040;
  localparam logic [58:0] DW  = {6'h00, 6'h20, 5'd9, 5'd10, 5'd8, 32'h0000_4020};
  localparam logic [58:0] DB  = {6'h04, 6'h3C, 5'd8, 5'd9, 5'd31, 32'hFFFF_FFFC};
  localparam logic [58:0] DJ1 = {6'h02, 6'h3F, 5'd31, 5'd31, 5'd31, 32'hFFFF_FFFF};
  localparam logic [58:0] DJ2 = {6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 32'h0000_0040};
  always #5 clk = ~clk;
  mod_instr_fetch #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .stall(stall), .branch(branch), .jump(jump), .zero(zero),
    .instr_valid(instr_valid), .instr(instr), .opcode(opcode), .funct(funct), .rs(rs), .rt(rt),
    .rd(rd), .imm_sext(imm_sext), .pc(pc), .pc_plus4(pc_plus4), .instr_count(instr_count));
  for (genvar g = 0; g < 2; g++) begin : gx
    mod_instr_fetch #(.RESET_PC(g == 0 ? 32'hFFFF_FFFC : 32'h0000_0003)) u (
      .clk(clk), .rst_n(rst2_n), .imem_req(x_req[g]), .imem_addr(x_addr[g]), .imem_ack(x_ack),
      .imem_rdata(x_rdata), .stall(x_zero), .branch(x_zero), .jump(x_zero), .zero(x_zero),
      .instr_valid(x_valid[g]), .instr(x_instr[g]), .opcode(x_op[g]), .funct(x_fn[g]), .rs(x_rs[g]),
      .rt(x_rt[g]), .rd(x_rd[g]), .imm_sext(x_imm[g]), .pc(x_pc[g]), .pc_plus4(x_pc4[g]),
      .instr_count(x_cnt[g]));
  end
  task automatic chk(input string nm, input logic [159:0] a, input logic [159:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (rst_n && imem_req && imem_ack) begin
      if (aq.size() == 0) chk("fetch_unexpected", aq.size(), 1);
      else chk("fetch_addr", imem_addr, aq.pop_front());
    end
    if (rst_n && instr_valid && !stall) begin
      if (iq.size() == 0) chk("issue_unexpected", iq.size(), 1);
      else chk("issue_record", {instr, opcode, funct, rs, rt, rd, imm_sext, pc, instr_count}, iq.pop_front());
    end
    if (rst2_n && x_req[0] && x_ack && wq.size() != 0) chk("wrap_addr", x_addr[0], wq.pop_front());
    if (rst2_n && x_req[1] && x_ack && oq.size() != 0) chk("unaligned_reset_addr", x_addr[1], oq.pop_front());
  end
  task automatic run(input logic [31:0] w, input logic [58:0] dec, input logic [31:0] addr,
                     input logic [31:0] cnt, input int nw = 0, input int ns = 0,
                     input logic br = 1'b0, input logic jp = 1'b0, input logic z = 1'b0);
    int n = 0;
    aq.push_back(addr);
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    chk("req_seen", imem_req, 1'b1);
    if (!imem_req) return;
    chk("valid_low_in_fetch", instr_valid, 1'b0);
    repeat (nw) begin
      step();
      chk("req_held", {imem_req, imem_addr, instr_valid}, {1'b1, addr, 1'b0});
    end
    imem_ack = 1'b1;
    imem_rdata = w;
    step();
    imem_ack = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk("issue_valid", {instr_valid, imem_req}, {1'b1, 1'b0});
    iq.push_back({w, dec, addr, cnt});
    if (ns > 0) begin
      stall = 1'b1;
      imem_ack = 1'b1;
      imem_rdata = 32'hFFFF_0000;
      repeat (ns) begin
        step();
        chk("stall_hold", {instr_valid, instr, pc, instr_count}, {1'b1, w, addr, cnt});
      end
      imem_ack = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
    end
    stall = 1'b0;
    branch = br;
    jump = jp;
    zero = z;
    step();
    branch = 1'b0;
    jump = 1'b0;
    zero = 1'b0;
    chk("count_inc", {instr_valid, instr_count}, {1'b0, cnt + 32'd1});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    wq.push_back(32'hFFFF_FFFC);
    wq.push_back(32'h0);
    wq.push_back(32'h4);
    oq.push_back(32'h0);
    oq.push_back(32'h4);
    repeat (3) step();
    chk("reset_state", {imem_req, instr_valid, pc, instr_count, instr}, 0);
    rst_n = 1'b1;
    rst2_n = 1'b1;
    chk("idle_after_reset", imem_req, 1'b0);
    step();
    chk("first_req", {imem_req, imem_addr}, {1'b1, 32'h0});
    run(W, DW, 32'h0, 0);
    run(W, DW, 32'h4, 1);
    run(W, DW, 32'h8, 2);
    chk("fetch_at_c", {imem_req, imem_addr}, {1'b1, 32'hC});
    rst_n = 1'b0;
    #1;
    chk("async_reset", {imem_req, instr_valid, pc, instr_count, instr, rd}, 0);
    imem_ack = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    chk("idle_late_ack", imem_req, 1'b0);
    step();
    imem_ack = 1'b0;
    chk("req_after_release", {imem_req, imem_addr, instr}, {1'b1, 32'h0, 32'h0});
    run(W, DW, 32'h0, 0);
    run(W, DW, 32'h4, 1);
    run(W, DW, 32'h8, 2);
    run(W, DW, 32'hC, 3);
    run(WB, DB, 32'h10, 4, 0, 0, 1'b1, 1'b0, 1'b1);
    run(W, DW, 32'h4, 5);
    run(W, DW, 32'h8, 6);
    run(W, DW, 32'hC, 7);
    run(WB, DB, 32'h10, 8, 0, 0, 1'b1, 1'b0, 1'b0);
    run(WJ1, DJ1, 32'h14, 9, 0, 0, 1'b0, 1'b1, 1'b0);
    run(W, DW, 32'h0FFF_FFFC, 10);
    run(WJ2, DJ2, 32'h1000_0000, 11, 0, 0, 1'b1, 1'b1, 1'b1);
    run(W, DW, 32'h1000_0100, 12, 3, 4);
    run(W, DW, 32'h1000_0104, 13);
    repeat (4) step();
    chk("queues_empty", {aq.size(), iq.size(), wq.size(), oq.size()}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
